// File: rtl/win7x13_gen.sv
// 7x13 sliding window generator: six line buffers feed a 7x13 register array,
// and a window is flagged valid only once it lies entirely inside one frame.
module win7x13_gen #(
  parameter int DW_PART = 9,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sof,
  input  logic                    pix_vld,
  input  logic [DW_PART-1:0]      pix_in,
  output logic                    win_vld,
  output logic [91*DW_PART-1:0]   win_data,
  output logic                    win_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          win_vld_q, win_vld_d;
  logic          win_eof_q, win_eof_d;

  logic [DW_PART-1:0] win_q [7][13];
  logic [DW_PART-1:0] win_d [7][13];

  // lb_mem[0] is the oldest line (six rows up), lb_mem[5] the previous line.
  logic [DW_PART-1:0] lb_mem [6][IMG_W];
  logic [DW_PART-1:0] lb_rd  [6];

  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    for (int unsigned k = 0; k < 6; k++) begin
      lb_rd[k] = lb_mem[k][cur_col];
    end
  end

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    win_vld_d = 1'b0;
    win_eof_d = 1'b0;
    win_d     = win_q;
    if (pix_vld) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      win_vld_d = (cur_row >= RW'(6)) && (cur_col >= CW'(12));
      win_eof_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      for (int unsigned r = 0; r < 7; r++) begin
        for (int unsigned c = 0; c < 12; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][12] = (r < 6) ? lb_rd[r] : pix_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      win_vld_q <= 1'b0;
      win_eof_q <= 1'b0;
      win_q     <= '{default: '0};
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      win_vld_q <= win_vld_d;
      win_eof_q <= win_eof_d;
      win_q     <= win_d;
    end
  end

  // Read-before-write: each buffer passes its old entry one line upward.
  always_ff @(posedge clk) begin
    if (pix_vld) begin
      for (int unsigned k = 0; k < 5; k++) begin
        lb_mem[k][cur_col] <= lb_mem[k+1][cur_col];
      end
      lb_mem[5][cur_col] <= pix_in;
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned r = 0; r < 7; r++) begin
      for (int unsigned c = 0; c < 13; c++) begin
        win_data[(r*13+c)*DW_PART +: DW_PART] = win_q[r][c];
      end
    end
  end

  assign win_vld = win_vld_q;
  assign win_eof = win_eof_q;

endmodule
